// File: rtl/debounce_pkg.sv
// Shared definitions for the debounced up/down counter: repeat FSM states,
// synchroniser depth, channel indices and default cycle counts.
package debounce_pkg;

    // Auto-repeat state of one button channel.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Flip-flops between the raw pad and the debouncer.
    localparam int SYNC_STAGES = 2;

    // Defaults sized for a 100 MHz board clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2_000_000;  // ~20 ms
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 50_000_000; // ~0.5 s
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = 10_000_000; // ~0.1 s

    // Bit positions of the three buttons in the top-level channel vectors.
    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_CLEAR = 2;
    localparam int NUM_CH   = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability-count debouncer and a
// registered press pulse. With DEBOUNCED_COUNTER_AUTOREPEAT_EN defined the
// channel also runs an auto-repeat FSM that adds pulses while held.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD,
    parameter bit          REPEAT_EN     = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_level;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q, stable_dly_d;
    logic                   press_q, press_d;

    assign sync_level = sync_q[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    // Count consecutive cycles of disagreement; accept the new level after
    // DEBOUNCE_CYCLES of them, any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_level != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Rising edge of the debounced level becomes a one-cycle press pulse.
    always_comb begin
        stable_dly_d = stable_q;
        press_d      = stable_q & ~stable_dly_q;
    end

    // Synchroniser, debouncer and pulse registers.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
        end
    end

`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
    localparam int TIMER_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    rpt_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               rep_q, rep_d;

    // Repeat FSM: wait REPEAT_DELAY after the press, then pulse every
    // REPEAT_PERIOD; releasing the button always returns to IDLE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rep_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_q && REPEAT_EN) begin
                    state_d = DELAY;
                    timer_d = '0;
                end
            end
            DELAY: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_W'(REPEAT_DELAY - 1)) begin
                    state_d = REPEAT;
                    timer_d = '0;
                    rep_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            REPEAT: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_W'(REPEAT_PERIOD - 1)) begin
                    timer_d = '0;
                    rep_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
        end
    end

    assign pulse_o = press_q | rep_q;
`else
    assign pulse_o = press_q;
`endif

endmodule

// File: rtl/debounced_updown_counter.sv
// Three debounced buttons (up, down, clear) driving a WIDTH-bit up/down
// counter that wraps or saturates. Optional auto-repeat on up/down is
// enabled by defining DEBOUNCED_COUNTER_AUTOREPEAT_EN.
module debounced_updown_counter
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          SATURATE        = 1'b0,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] count,
    output logic             limit
);

    // Reject configurations the counter and debouncer cannot implement.
    if (WIDTH < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("debounced_updown_counter: illegal parameter value");
    end

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [NUM_CH-1:0] raw_btn;
    logic [NUM_CH-1:0] pulse;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              limit_q, limit_d;

    assign raw_btn = {btn_clear, btn_down, btn_up};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (gi != CH_CLEAR)
`endif
        ) u_ch (
            .clk     (clk),
            .rst_n_i (reset),
            .btn_i   (raw_btn[gi]),
            .pulse_o (pulse[gi])
        );
    end

    // Next count by priority: clear, up+down cancel, up, down. limit flags
    // any step that crossed a boundary, whether it wrapped or was held.
    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        if (pulse[CH_CLEAR]) begin
            count_d = '0;
        end else if (pulse[CH_UP] && pulse[CH_DOWN]) begin
            count_d = count_q;
        end else if (pulse[CH_UP]) begin
            if (count_q == COUNT_MAX) begin
                limit_d = 1'b1;
                count_d = SATURATE ? COUNT_MAX : '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (pulse[CH_DOWN]) begin
            if (count_q == '0) begin
                limit_d = 1'b1;
                count_d = SATURATE ? '0 : COUNT_MAX;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Count and limit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    assign count = count_q;
    assign limit = limit_q;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: a wrapping and a saturating instance
// share stimulus; a behavioural model predicts count/limit every cycle, and
// directed phases pin hand-computed values.
module tb_debounced_updown_counter;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int MAXV = 15;
    localparam int HOLD = 8;
    localparam int GAP  = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic         btn_clear = 1'b0;
    logic [W-1:0] count_wrap, count_sat;
    logic         limit_wrap, limit_sat;

    int tests = 0;
    int fails = 0;
    int lim_seen [2];

    always #5 clk = ~clk;

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_wrap (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear), .count(count_wrap), .limit(limit_wrap)
    );

    debounced_updown_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_sat (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear), .count(count_sat), .limit(limit_sat)
    );

    // ---------------- behavioural model ----------------
    bit d1_m [3];     // raw level seen at the last edge
    bit syn_m [3];    // synchronised level
    bit stb_m [3];    // accepted level
    int streak_m [3]; // consecutive edges where synchronised != accepted
    bit rose_m [3];   // accepted level went high at the last edge
    bit prs_m [3];    // press pulse visible this cycle
    bit rep_m [2];    // repeat pulse visible this cycle
    bit alive_m [2];
    int age_m [2];
    int cnt_m [2];    // [0] wrapping, [1] saturating
    bit lim_m [2];

    task automatic model_step();
        bit raw [3];
        bit pul [3];
        raw[0] = btn_up;
        raw[1] = btn_down;
        raw[2] = btn_clear;
        if (!reset) begin
            for (int c = 0; c < 3; c++) begin
                d1_m[c] = 0; syn_m[c] = 0; stb_m[c] = 0;
                streak_m[c] = 0; rose_m[c] = 0; prs_m[c] = 0;
            end
            for (int s = 0; s < 2; s++) begin
                rep_m[s] = 0; alive_m[s] = 0; age_m[s] = 0;
                cnt_m[s] = 0; lim_m[s] = 0;
            end
        end else begin
            pul[0] = prs_m[0] | rep_m[0];
            pul[1] = prs_m[1] | rep_m[1];
            pul[2] = prs_m[2];
            for (int s = 0; s < 2; s++) begin
                lim_m[s] = 0;
                if (pul[2]) begin
                    cnt_m[s] = 0;
                end else if (pul[0] && pul[1]) begin
                    cnt_m[s] = cnt_m[s];
                end else if (pul[0]) begin
                    if (cnt_m[s] == MAXV) begin
                        lim_m[s] = 1;
                        cnt_m[s] = (s == 1) ? MAXV : 0;
                    end else begin
                        cnt_m[s] = cnt_m[s] + 1;
                    end
                end else if (pul[1]) begin
                    if (cnt_m[s] == 0) begin
                        lim_m[s] = 1;
                        cnt_m[s] = (s == 1) ? 0 : MAXV;
                    end else begin
                        cnt_m[s] = cnt_m[s] - 1;
                    end
                end
            end
`ifdef DEBOUNCED_COUNTER_AUTOREPEAT_EN
            // Extra pulses at RD, RD+RP, RD+2RP ... cycles into the hold.
            for (int c = 0; c < 2; c++) begin
                bit nrep;
                nrep = 0;
                if (prs_m[c]) begin
                    alive_m[c] = 1;
                    age_m[c] = 0;
                end else if (alive_m[c]) begin
                    if (!stb_m[c]) begin
                        alive_m[c] = 0;
                    end else begin
                        age_m[c] = age_m[c] + 1;
                        if (age_m[c] >= RD && ((age_m[c] - RD) % RP) == 0)
                            nrep = 1;
                    end
                end
                rep_m[c] = nrep;
            end
`endif
            for (int c = 0; c < 3; c++) begin
                prs_m[c] = rose_m[c];
                rose_m[c] = 0;
                if (syn_m[c] != stb_m[c]) begin
                    streak_m[c] = streak_m[c] + 1;
                    if (streak_m[c] == D) begin
                        stb_m[c] = syn_m[c];
                        streak_m[c] = 0;
                        rose_m[c] = stb_m[c];
                    end
                end else begin
                    streak_m[c] = 0;
                end
                syn_m[c] = d1_m[c];
                d1_m[c] = raw[c];
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: advance the model and check both DUTs every cycle.
    initial begin
        lim_seen[0] = 0;
        lim_seen[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            model_step();
            check("model_count_wrap", int'(count_wrap), cnt_m[0]);
            check("model_limit_wrap", int'(limit_wrap), int'(lim_m[0]));
            check("model_count_sat", int'(count_sat), cnt_m[1]);
            check("model_limit_sat", int'(limit_sat), int'(lim_m[1]));
            if (limit_wrap) lim_seen[0]++;
            if (limit_sat) lim_seen[1]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int ch, input logic v);
        case (ch)
            0:       btn_up = v;
            1:       btn_down = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic press(input int ch);
        set_btn(ch, 1'b1);
        cycles(HOLD);
        set_btn(ch, 1'b0);
        cycles(GAP);
    endtask

    task automatic press_n(input int ch, input int n);
        for (int i = 0; i < n; i++) press(ch);
    endtask

    task automatic check_both(input string name, input int exp_wrap, input int exp_sat);
        check({name, "_wrap"}, int'(count_wrap), exp_wrap);
        check({name, "_sat"}, int'(count_sat), exp_sat);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int lw, ls, base;
        cycles(3);
        check("reset_count", int'(count_wrap), 0);
        check("reset_limit", int'(limit_wrap), 0);
        reset = 1'b1;
        cycles(5);

        $display("[TB] phase clean_press");
        btn_up = 1'b1;
        cycles(7);
        check_both("press_before_edge8", 0, 0);
        cycles(1);
        check_both("press_at_edge8", 1, 1);
        cycles(2);
        btn_up = 1'b0;
        cycles(GAP);

        $display("[TB] phase bounce");
        lw = lim_seen[0];
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            cycles(2);
        end
        btn_up = 1'b0;
        cycles(12);
        check_both("bounce_no_change", 1, 1);
        check("bounce_no_limit", lim_seen[0] - lw, 0);

        $display("[TB] phase wrap_saturate");
        press(2);
        check_both("clear", 0, 0);
        lw = lim_seen[0]; ls = lim_seen[1];
        press_n(0, 16);
        check_both("up16", 0, 15);
        check("up16_limits_wrap", lim_seen[0] - lw, 1);
        check("up16_limits_sat", lim_seen[1] - ls, 1);
        lw = lim_seen[0]; ls = lim_seen[1];
        press_n(0, 4);
        check_both("up20", 4, 15);
        check("up20_limits_wrap", lim_seen[0] - lw, 0);
        check("up20_limits_sat", lim_seen[1] - ls, 4);
        press(2);
        lw = lim_seen[0]; ls = lim_seen[1];
        press(1);
        check_both("down_at_zero", 15, 0);
        check("down_limit_wrap", lim_seen[0] - lw, 1);
        check("down_limit_sat", lim_seen[1] - ls, 1);

        $display("[TB] phase priority");
        press(2);
        press_n(0, 9);
        check_both("up9", 9, 9);
        btn_up = 1'b1; btn_down = 1'b1;
        cycles(HOLD);
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(GAP);
        check_both("up_down_cancel", 9, 9);
        btn_up = 1'b1; btn_clear = 1'b1;
        cycles(HOLD);
        btn_up = 1'b0; btn_clear = 1'b0;
        cycles(GAP);
        check_both("clear_beats_up", 0, 0);

        $display("[TB] phase reset_mid_debounce");
        press_n(0, 5);
        check_both("up5", 5, 5);
        btn_up = 1'b1;
        cycles(3);
        reset = 1'b0;
        #1;
        check_both("async_reset", 0, 0);
        cycles(2);
        reset = 1'b1;
        cycles(20);
        check_both("held_through_reset", 1, 1);
        btn_up = 1'b0;
        cycles(GAP);

        $display("[TB] phase long_hold");
        base = int'(count_wrap);
        btn_up = 1'b1;
        cycles(46);
        btn_up = 1'b0;
        cycles(12);
`ifndef DEBOUNCED_COUNTER_AUTOREPEAT_EN
        check("long_hold_single_step", int'(count_wrap), (base + 1) % 16);
`endif

        $display("[TB] phase random");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                cycles(2);
                reset = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 29) == 0) btn_clear = ~btn_clear;
            cycles(1);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
